fft_reorder_pingpong: RTL and testbench
=======================================

// Module: fft_reorder_pingpong
// PURPOSE
//  Streaming output reorder buffer for the radix-2 SDF FFT pipeline, sized 2**LOG2N points.
//  Converts the final butterfly stage's bit-reversed sample stream into natural-order bins.
//  Supports continuous back-to-back frames through two ping-pong banks, valid/ready output
//  backpressure and frame resynchronisation. Sits between the last radix-2 stage and the
//  FFT top-level output port.
// PARAMETERS
//  LOG2N     6   log2 of FFT length; N = 2**LOG2N, legal range 2..10
//  DW        16  width of each real/imag sample component, two's complement
//  BITREV_IN 1   1: bit-reverse addressing on write, linear on read; 0: linear write, bit-reversed read
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input sample valid
//  in_ready   out  1      write bank can accept; transfer when in_valid && in_ready
//  in_sop     in   1      qualified by in_valid: sample is index 0 of a new frame
//  din_r      in   DW     input real part
//  din_i      in   DW     input imag part
//  out_valid  out  1      dout_* holds a valid bin
//  out_ready  in   1      downstream accepts; transfer when out_valid && out_ready
//  dout_r     out  DW     output real part
//  dout_i     out  DW     output imag part
//  dout_idx   out  LOG2N  natural bin index of dout_*
//  out_last   out  1      high with bin N-1
//  sop_err    out  1      one-cycle pulse: frame restarted by in_sop before N samples
// BEHAVIOUR
//  Reset values: out_valid=0, dout_r=0, dout_i=0, dout_idx=0, out_last=0, sop_err=0.
//   Both banks are empty and wr_sel=rd_sel=0. in_ready=1 from the first edge after reset release.
//  Write side state: wr_sel, wr_cnt[LOG2N-1:0], bank_full[1:0].
//   - in_ready = !bank_full[wr_sel].
//   - Accepted sample j goes to address bitrev(j) when BITREV_IN=1, or address j when BITREV_IN=0.
//   - When j=N-1 is accepted, set bank_full[wr_sel], toggle wr_sel and clear wr_cnt.
//  in_sop handling:
//   - Accepted sample with in_sop=1 and wr_cnt!=0: discard the partial frame, store this sample
//     as j=0 and set wr_cnt=1. Pulse sop_err for one cycle.
//   - in_sop=1 with wr_cnt=0 is normal. Samples without in_sop continue counting.
//  Read side state: rd_sel, rd_cnt. The output register advances when out_ready || !out_valid.
//   - On advance with bank_full[rd_sel]=1: load the entry at address rd_cnt (BITREV_IN=1) or
//     bitrev(rd_cnt) (BITREV_IN=0). Set dout_idx=rd_cnt, out_last=(rd_cnt==N-1), out_valid=1.
//   - On advance at rd_cnt==N-1: clear bank_full[rd_sel], toggle rd_sel and clear rd_cnt.
//   - On advance with no full bank: out_valid=0; dout_* hold their last value.
//  While out_valid && !out_ready, all outputs stay stable.
//  Latency: the last sample is accepted on edge t; bin 0 appears with out_valid=1 after edge t+1.
//  Throughput: with out_ready held high, one sample per clock sustains indefinitely with in_ready=1.
//  Simultaneous events:
//   - Clearing bank_full on the final read and the write side completing into the other bank in
//     the same cycle are independent.
//   - A bank freed on edge t has in_ready=1 after edge t.
//   - The write side never targets a full bank.
//  Reset mid-operation discards all data. Bank memory contents need no reset.
//  Arithmetic: no scaling or rounding; samples pass through bit-exact.
// STRUCTURE
//  fft_pkg (shared package) holds bitrev(x, LOG2N) and the default FFT length and DW constants.
//  Sub-module fft_reorder_bank: N x 2*DW register bank with one write and one read port. It is
//   instantiated twice. Top level contains counters, bank flags and the output register.
// TESTING
//  1 LOG2N=3, BITREV_IN=1, out_ready=1; feed j-th sample value bitrev(j) for j=0..7
//    -> dout_r=0..7 in order, dout_idx=0..7, out_last only with 7.
//  2 LOG2N=6; 4 back-to-back frames at full rate, out_ready=1
//    -> in_ready never low; 256 outputs contiguous; each frame equals a golden bit-reverse model.
//  3 out_ready=0 from the start; stream input -> in_ready drops after 128 accepted samples;
//    dout_* frozen at bin 0 of frame 0. Release out_ready -> no loss, 128 bins in order.
//  4 in_sop asserted with sample 5 of a frame -> sop_err pulse one cycle; that sample becomes
//    j=0; the next emitted frame contains only the restarted data.
//  5 rst_n asserted mid-drain at bin 20 -> outputs at reset values immediately; the next frame
//    after release emits correctly from bin 0.
//  6 BITREV_IN=0, linear ramp input 0..63 -> dout_r sequence is bitrev(k), dout_idx=k.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reversal helper used by the reorder buffer.
package fft_pkg;

    localparam int FFT_LOG2N_DEF = 6;
    localparam int FFT_DW_DEF    = 16;
    localparam int FFT_LOG2N_MAX = 10;

    typedef logic [FFT_LOG2N_MAX-1:0] fft_idx_t;

    // Reverses the low nbits of x; bits at and above nbits come back as zero.
    function automatic fft_idx_t bitrev(input fft_idx_t x, input int nbits);
        fft_idx_t r;
        r = '0;
        for (int i = 0; i < FFT_LOG2N_MAX; i++) begin
            if (i < nbits) begin
                r[i] = x[nbits-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: N x W storage, one synchronous write port, one combinational read port.
module fft_reorder_bank #(
    parameter int AW = 6,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The top-level output register is the read pipeline stage.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_reorder_pingpong.sv
// Bit-reversed to natural-order reorder buffer with two ping-pong banks and valid/ready output.
module fft_reorder_pingpong
    import fft_pkg::*;
#(
    parameter int LOG2N     = FFT_LOG2N_DEF,
    parameter int DW        = FFT_DW_DEF,
    parameter bit BITREV_IN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic [DW-1:0]    din_r,
    input  logic [DW-1:0]    din_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    dout_r,
    output logic [DW-1:0]    dout_i,
    output logic [LOG2N-1:0] dout_idx,
    output logic             out_last,
    output logic             sop_err
);

    logic [1:0]       r_bank_full;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [LOG2N-1:0] r_wr_cnt;
    logic [LOG2N-1:0] r_rd_cnt;
    logic             r_out_valid;
    logic [DW-1:0]    r_dout_r;
    logic [DW-1:0]    r_dout_i;
    logic [LOG2N-1:0] r_dout_idx;
    logic             r_out_last;
    logic             r_sop_err;

    logic             w_in_fire;
    logic             w_restart;
    logic [LOG2N-1:0] w_j;
    logic             w_wr_last;
    logic [LOG2N-1:0] w_wr_addr;
    logic [LOG2N-1:0] w_rd_addr;
    logic             w_adv;
    logic             w_rd_fire;
    logic             w_rd_last;
    logic [1:0]       w_full_set;
    logic [1:0]       w_full_clr;
    logic [1:0]       w_we;
    logic [2*DW-1:0]  w_rd_data [2];
    logic [2*DW-1:0]  w_rd_word;

    assign in_ready  = !r_bank_full[r_wr_sel];
    assign w_in_fire = in_valid && in_ready;

    // A mid-frame sop throws away the partial frame and restarts this sample at index 0.
    assign w_restart = w_in_fire && in_sop && (r_wr_cnt != '0);
    assign w_j       = w_restart ? '0 : r_wr_cnt;
    assign w_wr_last = w_in_fire && (&w_j);
    assign w_wr_addr = BITREV_IN ? LOG2N'(bitrev(fft_idx_t'(w_j), LOG2N)) : w_j;

    assign w_adv     = out_ready || !r_out_valid;
    assign w_rd_fire = w_adv && r_bank_full[r_rd_sel];
    assign w_rd_last = &r_rd_cnt;
    assign w_rd_addr = BITREV_IN ? r_rd_cnt : LOG2N'(bitrev(fft_idx_t'(r_rd_cnt), LOG2N));
    assign w_rd_word = w_rd_data[r_rd_sel];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign w_we[gi]       = w_in_fire && (r_wr_sel == 1'(gi));
            assign w_full_set[gi] = w_wr_last && (r_wr_sel == 1'(gi));
            assign w_full_clr[gi] = w_rd_fire && w_rd_last && (r_rd_sel == 1'(gi));

            fft_reorder_bank #(
                .AW (LOG2N),
                .W  (2*DW)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_we[gi]),
                .i_waddr (w_wr_addr),
                .i_wdata ({din_r, din_i}),
                .i_raddr (w_rd_addr),
                .o_rdata (w_rd_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_full <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_dout_r    <= '0;
            r_dout_i    <= '0;
            r_dout_idx  <= '0;
            r_out_last  <= 1'b0;
            r_sop_err   <= 1'b0;
        end else begin
            r_sop_err   <= w_restart;
            // Write and read always target different banks, so set and clear never collide.
            r_bank_full <= (r_bank_full | w_full_set) & ~w_full_clr;

            if (w_in_fire) begin
                r_wr_cnt <= w_wr_last ? '0 : w_j + 1'b1;
                if (w_wr_last) begin
                    r_wr_sel <= ~r_wr_sel;
                end
            end

            if (w_rd_fire) begin
                {r_dout_r, r_dout_i} <= w_rd_word;
                r_dout_idx  <= r_rd_cnt;
                r_out_last  <= w_rd_last;
                r_out_valid <= 1'b1;
                r_rd_cnt    <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
                if (w_rd_last) begin
                    r_rd_sel <= ~r_rd_sel;
                end
            end else if (w_adv) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout_r    = r_dout_r;
    assign dout_i    = r_dout_i;
    assign dout_idx  = r_dout_idx;
    assign out_last  = r_out_last;
    assign sop_err   = r_sop_err;

endmodule

// File: tb/tb_fft_reorder_pingpong.sv
// Randomized bench for fft_reorder_pingpong, checked against a frame-level reorder model.
module tb_fft_reorder_pingpong;

    localparam int N = 64;

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        int          idx;
        bit          last;
    } exp_t;

    logic        clk;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sop = 1'b0;
    logic [15:0] din_r = '0;
    logic [15:0] din_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] dout_r;
    logic [15:0] dout_i;
    logic [5:0]  dout_idx;
    logic        out_last;
    logic        sop_err;

    logic        l_in_valid = 1'b0;
    logic        l_in_ready;
    logic        l_in_sop = 1'b0;
    logic [7:0]  l_din_r = '0;
    logic [7:0]  l_din_i = '0;
    logic        l_out_valid;
    logic        l_out_ready = 1'b1;
    logic [7:0]  l_dout_r;
    logic [7:0]  l_dout_i;
    logic [2:0]  l_dout_idx;
    logic        l_out_last;
    logic        l_sop_err;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q[$];
    logic [31:0] cur_q[$];
    bit          exp_sop = 0;
    bit          hold = 0;
    logic [39:0] hold_val = '0;
    int          ready_mode = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          stall_cnt = 0;
    int          sop_pulses = 0;
    int          tx_cnt = 0;
    int          first_tx = -1;
    int          last_tx = -1;
    int          frames_out = 0;
    int          l_k = 0;

    fft_reorder_pingpong #(.LOG2N(6), .DW(16), .BITREV_IN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .din_r(din_r), .din_i(din_i), .out_valid(out_valid), .out_ready(out_ready),
        .dout_r(dout_r), .dout_i(dout_i), .dout_idx(dout_idx), .out_last(out_last),
        .sop_err(sop_err)
    );

    fft_reorder_pingpong #(.LOG2N(3), .DW(8), .BITREV_IN(1'b0)) u_dut_lin (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_sop(l_in_sop),
        .din_r(l_din_r), .din_i(l_din_i), .out_valid(l_out_valid), .out_ready(l_out_ready),
        .dout_r(l_dout_r), .dout_i(l_dout_i), .dout_idx(l_dout_idx), .out_last(l_out_last),
        .sop_err(l_sop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int brev(input int x, input int n);
        int r;
        r = 0;
        for (int b = 0; b < n; b++) r = r * 2 + ((x >> b) & 1);
        return r;
    endfunction

    // Reference: bin k of a frame is input sample bitrev(k), whatever the addressing mode.
    task automatic model_accept(input logic [15:0] r, input logic [15:0] i, input logic sop);
        exp_t e;
        logic [31:0] w;
        if (sop && cur_q.size() != 0) begin
            cur_q.delete();
            exp_sop = 1;
        end
        cur_q.push_back({r, i});
        if (cur_q.size() == N) begin
            for (int k = 0; k < N; k++) begin
                w      = cur_q[brev(k, 6)];
                e.r    = w[31:16];
                e.i    = w[15:0];
                e.idx  = k;
                e.last = (k == N - 1);
                exp_q.push_back(e);
            end
            cur_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cyc++;
                check("sop_err", 64'(sop_err), 64'(exp_sop));
                exp_sop = 0;
                if (sop_err) sop_pulses++;
                if (hold) check("hold_stable", 64'({out_valid, dout_r, dout_i, dout_idx, out_last}), 64'(hold_val));
                hold     = out_valid && !out_ready;
                hold_val = {out_valid, dout_r, dout_i, dout_idx, out_last};
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("dout_r", 64'(dout_r), 64'(e.r));
                        check("dout_i", 64'(dout_i), 64'(e.i));
                        check("dout_idx", 64'(dout_idx), 64'(e.idx));
                        check("out_last", 64'(out_last), 64'(e.last));
                        tx_cnt++;
                        if (first_tx < 0) first_tx = cyc;
                        last_tx = cyc;
                        if (e.last) begin
                            frames_out++;
                            $display("[TB] frame %0d emitted at cycle %0d, failures so far %0d", frames_out, cyc, n_fail);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    acc_cnt++;
                    model_accept(din_r, din_i, in_sop);
                end
                if (in_valid && !in_ready) stall_cnt++;
            end
        end
    end

    initial begin : lin_monitor
        logic [7:0] er;
        forever begin
            @(negedge clk);
            if (rst_n && l_out_valid && l_out_ready) begin
                er = 8'(8 * (l_k / 8) + brev(l_k % 8, 3));
                check("lin_dout_r", 64'(l_dout_r), 64'(er));
                check("lin_dout_i", 64'(l_dout_i), 64'(8'(~er)));
                check("lin_dout_idx", 64'(l_dout_idx), 64'(l_k % 8));
                check("lin_out_last", 64'(l_out_last), 64'((l_k % 8) == 7));
                l_k++;
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        cur_q.delete();
        exp_sop = 0;
        hold    = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_dout_r", 64'(dout_r), 64'(0));
        check("rst_dout_i", 64'(dout_i), 64'(0));
        check("rst_dout_idx", 64'(dout_idx), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_sop_err", 64'(sop_err), 64'(0));
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] r, input logic [15:0] i, input logic sop, input bit gaps);
        bit acc;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        din_r    = r;
        din_i    = i;
        in_sop   = sop;
        acc      = 0;
        for (int c = 0; c < 2000 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_frame(input int len, input bit gaps);
        for (int j = 0; j < len; j++) send(16'($urandom), 16'($urandom), j == 0, gaps);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 4000 && (exp_q.size() != 0 || out_valid); c++) @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin : timeout_guard
        #1_000_000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stimulus
        int  n_part;
        bit  found;
        #2;
        do_reset();

        // Four back-to-back frames at full rate.
        ready_mode = 0;
        stall_cnt  = 0;
        tx_cnt     = 0;
        first_tx   = -1;
        for (int f = 0; f < 4; f++) send_frame(N, 0);
        wait_drain("t2_drain");
        check("t2_in_ready_stalls", 64'(stall_cnt), 64'(0));
        check("t2_out_count", 64'(tx_cnt), 64'(4 * N));
        check("t2_out_contiguous", 64'(last_tx - first_tx), 64'(4 * N - 1));

        // Output blocked from the start: both banks fill, output frozen on bin 0.
        ready_mode = 1;
        acc_cnt    = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(N, 0);
            end
            begin
                repeat (300) @(negedge clk);
                #1;
                check("t3_accepted", 64'(acc_cnt), 64'(2 * N));
                check("t3_in_ready", 64'(in_ready), 64'(0));
                check("t3_out_valid", 64'(out_valid), 64'(1));
                check("t3_dout_idx", 64'(dout_idx), 64'(0));
                if (exp_q.size() != 0) check("t3_dout_r", 64'(dout_r), 64'(exp_q[0].r));
                else check("t3_model_empty", 64'(0), 64'(1));
                ready_mode = 2;
            end
        join
        wait_drain("t3_drain");

        // Restart on sample 5 of a frame.
        sop_pulses = 0;
        send_frame(5, 1);
        send_frame(N, 1);
        wait_drain("t4_drain");
        check("t4_sop_pulses", 64'(sop_pulses), 64'(1));

        // Reset while bin 20 is on the output.
        ready_mode = 0;
        send_frame(N, 0);
        found = 0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            found = out_valid && (dout_idx == 6'd20);
        end
        check("t5_reach_bin20", 64'(found), 64'(1));
        #2;
        do_reset();
        ready_mode = 2;
        send_frame(N, 1);
        wait_drain("t5_drain");

        // Random soak with occasional truncated frames.
        sop_pulses = 0;
        n_part     = 0;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                send_frame(int'($urandom_range(1, N - 1)), 1);
                n_part++;
            end
            send_frame(N, 1);
        end
        wait_drain("soak_drain");
        check("soak_sop_pulses", 64'(sop_pulses), 64'(n_part));

        // Linear-write instance: ramp input must come out as bit-reversed values.
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 8; j++) begin
                l_in_valid = 1'b1;
                l_din_r    = 8'(8 * f + j);
                l_din_i    = ~l_din_r;
                l_in_sop   = (j == 0);
                @(negedge clk);
                check("lin_in_ready", 64'(l_in_ready), 64'(1));
                @(posedge clk);
                #1;
            end
        end
        l_in_valid = 1'b0;
        l_in_sop   = 1'b0;
        repeat (30) @(posedge clk);
        check("lin_count", 64'(l_k), 64'(16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
